// File: rtl/fault_seq_pkg.sv
// Shared types and constants for the fault-injection sequencer.
//   state_e      : campaign FSM states
//   POL_*        : polarity-mode encodings for the POL_MODE parameter
//   clog2_min1() : width helper, never returns less than 1
package fault_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int POL_SA0_SA1 = 0;
    localparam int POL_SA0     = 1;
    localparam int POL_SA1     = 2;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fault_seq_window_cnt.sv
// Dwell-window counter: counts patterns applied under the current fault.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   run        : sequencer is in RUN (gates counting and win_last)
//   inc        : one pattern applied
//   clear      : synchronous clear (start accepted / abort), beats inc
//   pat_cnt    : patterns done in the current window
//   win_last   : next inc closes the window
module fault_seq_window_cnt
    import fault_seq_pkg::*;
#(
    parameter  int PATS_PER_FAULT = 1,
    localparam int PAT_W          = clog2_min1(PATS_PER_FAULT)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             inc,
    input  logic             clear,
    output logic [PAT_W-1:0] pat_cnt,
    output logic             win_last
);

    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(PATS_PER_FAULT - 1);

    logic [PAT_W-1:0] pat_cnt_q;
    logic [PAT_W-1:0] pat_cnt_d;

    assign win_last = run && (pat_cnt_q == LAST_PAT);
    assign pat_cnt  = pat_cnt_q;

    always_comb begin
        pat_cnt_d = pat_cnt_q;
        if (clear) begin
            pat_cnt_d = '0;
        end else if (run && inc) begin
            pat_cnt_d = win_last ? '0 : pat_cnt_q + PAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_cnt_q <= '0;
        end else begin
            pat_cnt_q <= pat_cnt_d;
        end
    end

endmodule

// File: rtl/fault_seq_ctrl.sv
// Fault-injection sequencer: walks every fault site for each selected
// stuck-at polarity, holding each fault for PATS_PER_FAULT patterns.
// Optional feature macro: FAULT_SEQ_DETCNT_EN (adds fault_det / det_cnt
// and a per-window detection counter).
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : begin campaign (IDLE or DONE only)
//   abort            : synchronous return to IDLE, highest priority
//   inc              : one pattern applied under the current fault
//   fen              : one-hot site enable, zero outside RUN
//   fault            : stuck-at value for the enabled site
//   site_idx         : binary index of the enabled site
//   pat_cnt          : patterns done in the current window
//   win_last         : next inc closes the window
//   busy, done       : state is RUN / DONE
//   fault_det        : (optional) netlist mismatch seen for this pattern
//   det_cnt          : (optional) windows in which the fault was detected
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no campaign, netlist fault-free
// RUN     | fault applied, counting patterns per window
// DONE    | campaign finished, site_idx/fault held
module fault_seq_ctrl
    import fault_seq_pkg::*;
#(
    parameter  int NSITES         = 10,
    parameter  int PATS_PER_FAULT = 1,
    parameter  int POL_MODE       = 0,
    localparam int SITE_W         = clog2_min1(NSITES),
    localparam int PAT_W          = clog2_min1(PATS_PER_FAULT)
`ifdef FAULT_SEQ_DETCNT_EN
    ,
    localparam int DET_W          = $clog2(2*NSITES + 1)
`endif
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              inc,
`ifdef FAULT_SEQ_DETCNT_EN
    input  logic              fault_det,
    output logic [DET_W-1:0]  det_cnt,
`endif
    output logic [NSITES-1:0] fen,
    output logic              fault,
    output logic [SITE_W-1:0] site_idx,
    output logic [PAT_W-1:0]  pat_cnt,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    localparam logic [SITE_W-1:0] LAST_SITE = SITE_W'(NSITES - 1);
    localparam logic              FIRST_POL = (POL_MODE == POL_SA1);

    state_e             state_q, state_d;
    logic [NSITES-1:0]  fen_q, fen_d;
    logic [SITE_W-1:0]  site_idx_q, site_idx_d;
    logic               fault_q, fault_d;

    logic run;
    logic start_ok;
    logic win_close;
    logic last_site;
    logic second_pass;

    assign run         = (state_q == ST_RUN);
    assign start_ok    = start && !run;
    assign win_close   = run && inc && win_last;
    assign last_site   = (site_idx_q == LAST_SITE);
    // SA0 pass just finished and an SA1 pass is still owed
    assign second_pass = (POL_MODE == POL_SA0_SA1) && !fault_q;

    fault_seq_window_cnt #(
        .PATS_PER_FAULT (PATS_PER_FAULT)
    ) u_window_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .inc      (inc),
        .clear    (abort || start_ok),
        .pat_cnt  (pat_cnt),
        .win_last (win_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
                ST_RUN:           if (win_close && last_site && !second_pass) state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Site ring / polarity datapath
    always_comb begin
        fen_d      = fen_q;
        site_idx_d = site_idx_q;
        fault_d    = fault_q;
        if (abort) begin
            fen_d      = '0;
            site_idx_d = '0;
            fault_d    = 1'b0;
        end else if (start_ok) begin
            fen_d      = NSITES'(1);
            site_idx_d = '0;
            fault_d    = FIRST_POL;
        end else if (win_close) begin
            if (!last_site) begin
                fen_d      = {fen_q[NSITES-2:0], fen_q[NSITES-1]};
                site_idx_d = site_idx_q + SITE_W'(1);
            end else if (second_pass) begin
                fen_d      = NSITES'(1);
                site_idx_d = '0;
                fault_d    = 1'b1;
            end else begin
                // campaign end: release the netlist, keep site/polarity for readback
                fen_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fen_q      <= '0;
            site_idx_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            fen_q      <= fen_d;
            site_idx_q <= site_idx_d;
            fault_q    <= fault_d;
        end
    end

    assign fen      = fen_q;
    assign site_idx = site_idx_q;
    assign fault    = fault_q;

`ifdef FAULT_SEQ_DETCNT_EN
    logic             det_flag_q, det_flag_d;
    logic [DET_W-1:0] det_cnt_q, det_cnt_d;

    always_comb begin
        det_flag_d = det_flag_q;
        det_cnt_d  = det_cnt_q;
        if (abort || start_ok) begin
            det_flag_d = 1'b0;
            det_cnt_d  = '0;
        end else if (win_close) begin
            // the closing pattern's own detection still counts for this window
            det_flag_d = 1'b0;
            if ((det_flag_q || fault_det) && (det_cnt_q != {DET_W{1'b1}})) begin
                det_cnt_d = det_cnt_q + DET_W'(1);
            end
        end else if (run && inc && fault_det) begin
            det_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_flag_q <= 1'b0;
            det_cnt_q  <= '0;
        end else begin
            det_flag_q <= det_flag_d;
            det_cnt_q  <= det_cnt_d;
        end
    end

    assign det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_fault_seq_ctrl.sv
// Bench for fault_seq_ctrl: several parameterisations driven by shared
// stimulus, each checked every cycle against a window-count model, plus
// hand-computed literal checkpoints.
module tb_fault_seq_ctrl;

`ifdef FAULT_SEQ_DETCNT_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif

    // per-instance parameters: A, B, C, D
    localparam int PN [4] = '{4, 3, 4, 4};
    localparam int PP [4] = '{1, 3, 1, 2};
    localparam int PM [4] = '{0, 0, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort, inc, fault_det;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] a_fen;  logic a_fault; logic [1:0] a_site; logic [0:0] a_pat; logic a_wl, a_busy, a_done;
    logic [2:0] b_fen;  logic b_fault; logic [1:0] b_site; logic [1:0] b_pat; logic b_wl, b_busy, b_done;
    logic [3:0] c_fen;  logic c_fault; logic [1:0] c_site; logic [0:0] c_pat; logic c_wl, c_busy, c_done;
`ifdef FAULT_SEQ_DETCNT_EN
    logic [3:0] d_fen;  logic d_fault; logic [1:0] d_site; logic [0:0] d_pat; logic d_wl, d_busy, d_done;
    logic [3:0] a_det;  logic [2:0] b_det; logic [3:0] c_det; logic [3:0] d_det;
`endif

    fault_seq_ctrl #(.NSITES(4), .PATS_PER_FAULT(1), .POL_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inc(inc),
`ifdef FAULT_SEQ_DETCNT_EN
        .fault_det(fault_det), .det_cnt(a_det),
`endif
        .fen(a_fen), .fault(a_fault), .site_idx(a_site), .pat_cnt(a_pat),
        .win_last(a_wl), .busy(a_busy), .done(a_done));

    fault_seq_ctrl #(.NSITES(3), .PATS_PER_FAULT(3), .POL_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inc(inc),
`ifdef FAULT_SEQ_DETCNT_EN
        .fault_det(fault_det), .det_cnt(b_det),
`endif
        .fen(b_fen), .fault(b_fault), .site_idx(b_site), .pat_cnt(b_pat),
        .win_last(b_wl), .busy(b_busy), .done(b_done));

    fault_seq_ctrl #(.NSITES(4), .PATS_PER_FAULT(1), .POL_MODE(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inc(inc),
`ifdef FAULT_SEQ_DETCNT_EN
        .fault_det(fault_det), .det_cnt(c_det),
`endif
        .fen(c_fen), .fault(c_fault), .site_idx(c_site), .pat_cnt(c_pat),
        .win_last(c_wl), .busy(c_busy), .done(c_done));

`ifdef FAULT_SEQ_DETCNT_EN
    fault_seq_ctrl #(.NSITES(4), .PATS_PER_FAULT(2), .POL_MODE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inc(inc),
        .fault_det(fault_det), .det_cnt(d_det),
        .fen(d_fen), .fault(d_fault), .site_idx(d_site), .pat_cnt(d_pat),
        .win_last(d_wl), .busy(d_busy), .done(d_done));
`endif

    // gather outputs into uniform arrays for the compare process
    int o_fen [NI], o_fault [NI], o_site [NI], o_pat [NI], o_wl [NI], o_busy [NI], o_done [NI];
    assign o_fen[0] = int'(a_fen); assign o_fault[0] = int'(a_fault); assign o_site[0] = int'(a_site);
    assign o_pat[0] = int'(a_pat); assign o_wl[0] = int'(a_wl); assign o_busy[0] = int'(a_busy); assign o_done[0] = int'(a_done);
    assign o_fen[1] = int'(b_fen); assign o_fault[1] = int'(b_fault); assign o_site[1] = int'(b_site);
    assign o_pat[1] = int'(b_pat); assign o_wl[1] = int'(b_wl); assign o_busy[1] = int'(b_busy); assign o_done[1] = int'(b_done);
    assign o_fen[2] = int'(c_fen); assign o_fault[2] = int'(c_fault); assign o_site[2] = int'(c_site);
    assign o_pat[2] = int'(c_pat); assign o_wl[2] = int'(c_wl); assign o_busy[2] = int'(c_busy); assign o_done[2] = int'(c_done);
`ifdef FAULT_SEQ_DETCNT_EN
    assign o_fen[3] = int'(d_fen); assign o_fault[3] = int'(d_fault); assign o_site[3] = int'(d_site);
    assign o_pat[3] = int'(d_pat); assign o_wl[3] = int'(d_wl); assign o_busy[3] = int'(d_busy); assign o_done[3] = int'(d_done);
    int o_det [NI];
    assign o_det[0] = int'(a_det); assign o_det[1] = int'(b_det);
    assign o_det[2] = int'(c_det); assign o_det[3] = int'(d_det);
`endif

    // Model: mst 0=idle 1=run 2=done; mwin = index of current (or final) window,
    // mpc = patterns done in it. Site and polarity follow from the window index.
    int mst [NI], mwin [NI], mpc [NI], mflag [NI], mdet [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                mst[i] <= 0; mwin[i] <= 0; mpc[i] <= 0; mflag[i] <= 0; mdet[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (abort) begin
                    mst[i] <= 0; mwin[i] <= 0; mpc[i] <= 0; mflag[i] <= 0; mdet[i] <= 0;
                end else if (mst[i] != 1 && start) begin
                    mst[i] <= 1; mwin[i] <= 0; mpc[i] <= 0; mflag[i] <= 0; mdet[i] <= 0;
                end else if (mst[i] == 1 && inc) begin
                    if (mpc[i] == PP[i] - 1) begin
                        mpc[i]   <= 0;
                        mflag[i] <= 0;
                        if ((mflag[i] != 0 || fault_det) && mdet[i] < (1 << $clog2(2*PN[i]+1)) - 1)
                            mdet[i] <= mdet[i] + 1;
                        if (mwin[i] == PN[i] * ((PM[i] == 0) ? 2 : 1) - 1) mst[i] <= 2;
                        else mwin[i] <= mwin[i] + 1;
                    end else begin
                        mpc[i] <= mpc[i] + 1;
                        if (fault_det) mflag[i] <= 1;
                    end
                end
            end
        end
    end

    task automatic cmp(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int efen, esite, efault, epat, ewl, ebusy, edone, pol;
            pol   = (PM[i] == 2 || (PM[i] == 0 && mwin[i] >= PN[i])) ? 1 : 0;
            efen  = 0; esite = 0; efault = 0; epat = 0; ewl = 0; ebusy = 0; edone = 0;
            if (mst[i] == 1) begin
                efen = 1 << (mwin[i] % PN[i]); esite = mwin[i] % PN[i]; efault = pol;
                epat = mpc[i]; ewl = (mpc[i] == PP[i] - 1) ? 1 : 0; ebusy = 1;
            end else if (mst[i] == 2) begin
                esite = mwin[i] % PN[i]; efault = pol; edone = 1;
            end
            cmp("fen", i, o_fen[i], efen);
            cmp("site_idx", i, o_site[i], esite);
            cmp("fault", i, o_fault[i], efault);
            cmp("pat_cnt", i, o_pat[i], epat);
            cmp("win_last", i, o_wl[i], ewl);
            cmp("busy", i, o_busy[i], ebusy);
            cmp("done", i, o_done[i], edone);
`ifdef FAULT_SEQ_DETCNT_EN
            cmp("det_cnt", i, o_det[i], mdet[i]);
`endif
        end
    end

    task automatic step(input logic s, input logic a, input logic i, input logic fd);
        start = s; abort = a; inc = i; fault_det = fd;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; inc = 1'b0; fault_det = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; inc = 1'b0; fault_det = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("lit_reset_fen", 0, int'(a_fen), 0);
        cmp("lit_reset_busy", 0, int'(a_busy), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);

        // start: one cycle to fen valid
        step(1, 0, 0, 0);
        cmp("lit_start_fen", 0, int'(a_fen), 1);
        cmp("lit_start_fault", 0, int'(a_fault), 0);
        cmp("lit_sa1_fault", 2, int'(c_fault), 1);
        cmp("lit_start_fen", 1, int'(b_fen), 1);

        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0);
            if (k < 8) begin
                cmp("lit_walk_fen", 0, int'(a_fen), 1 << (k % 4));
                cmp("lit_walk_fault", 0, int'(a_fault), (k >= 4) ? 1 : 0);
            end else begin
                cmp("lit_end_done", 0, int'(a_done), 1);
                cmp("lit_end_fen", 0, int'(a_fen), 0);
            end
            if (k == 2) begin
                cmp("lit_dwell_pat", 1, int'(b_pat), 2);
                cmp("lit_dwell_wl", 1, int'(b_wl), 1);
                cmp("lit_dwell_fen", 1, int'(b_fen), 1);
            end
            if (k == 3) begin
                cmp("lit_dwell_adv_fen", 1, int'(b_fen), 2);
                cmp("lit_dwell_adv_pat", 1, int'(b_pat), 0);
            end
            if (k == 4) begin
                cmp("lit_sa1_done", 2, int'(c_done), 1);
                cmp("lit_sa1_fen", 2, int'(c_fen), 0);
                cmp("lit_sa1_hold", 2, int'(c_fault), 1);
            end
        end

        // restart from DONE; start in RUN ignored
        step(1, 0, 0, 0);
        cmp("lit_restart_fen", 0, int'(a_fen), 1);
        cmp("lit_restart_fault", 0, int'(a_fault), 0);
        cmp("lit_restart_done", 0, int'(a_done), 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        cmp("lit_start_in_run", 0, int'(a_fen), 2);
        step(0, 0, 1, 0);
        cmp("lit_site2", 0, int'(a_site), 2);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        cmp("lit_async_fen", 0, int'(a_fen), 0);
        cmp("lit_async_site", 0, int'(a_site), 0);
        cmp("lit_async_busy", 0, int'(a_busy), 0);
        cmp("lit_async_fen", 1, int'(b_fen), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // abort beats inc
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        cmp("lit_abort_fen", 0, int'(a_fen), 0);
        cmp("lit_abort_busy", 0, int'(a_busy), 0);
        cmp("lit_abort_fen", 1, int'(b_fen), 0);

        // detection windows: fault_det on 1st inc of windows 0 and 2
        step(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) step(0, 0, 1, (k == 1 || k == 5) ? 1'b1 : 1'b0);
`ifdef FAULT_SEQ_DETCNT_EN
        cmp("lit_det_done", 3, int'(d_done), 1);
        cmp("lit_det_cnt", 3, int'(d_det), 2);
`endif
        // run the long-dwell instance through to the end of both passes
        for (int k = 0; k < 12; k++) step(0, 0, 1, k[0]);
        cmp("lit_dwell_done", 1, int'(b_done), 1);
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
